// File: rtl/hippo_irq_pkg.sv
// Shared types for the hippo interrupt scheduler: stack command encoding,
// FSM state encoding and default parameters.
package hippo_irq_pkg;

    localparam int unsigned DEF_NUM_IRQ    = 8;
    localparam int unsigned DEF_PRIO_WIDTH = 3;
    localparam int unsigned DEF_MAX_DEPTH  = 4;

    // Same encoding as the stacked register file command input.
    typedef enum logic [1:0] {
        STACK_NONE = 2'd0,
        STACK_PUSH = 2'd1,
        STACK_POP  = 2'd2
    } stack_cmd_e;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_REQ   = 2'd1,
        FSM_ENTER = 2'd2,
        FSM_EXIT  = 2'd3
    } fsm_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hippo_irq_scheduler_if.sv
// Core-side handshake of the interrupt scheduler: request, accept, mret and
// the stacked register file command.
interface hippo_irq_scheduler_if
    import hippo_irq_pkg::*;
#(
    parameter int unsigned NumIrq    = DEF_NUM_IRQ,
    parameter int unsigned PrioWidth = DEF_PRIO_WIDTH
) ();
    localparam int unsigned IdWidth = idx_width(NumIrq);

    logic                 req_o;
    logic [IdWidth-1:0]   req_id_o;
    logic [PrioWidth-1:0] req_prio_o;
    logic                 ack_i;
    logic                 mret_i;
    stack_cmd_e           stack_cmd_o;

    modport master (
        output req_o, req_id_o, req_prio_o, stack_cmd_o,
        input  ack_i, mret_i
    );

    modport slave (
        input  req_o, req_id_o, req_prio_o, stack_cmd_o,
        output ack_i, mret_i
    );
endinterface

// File: rtl/hippo_irq_prio_select.sv
// Combinational arbiter: highest priority among valid lines, lowest index
// wins a tie.
module hippo_irq_prio_select
    import hippo_irq_pkg::*;
#(
    parameter int unsigned NumIrq    = DEF_NUM_IRQ,
    parameter int unsigned PrioWidth = DEF_PRIO_WIDTH,
    localparam int unsigned IdWidth  = idx_width(NumIrq)
) (
    input  logic [NumIrq-1:0]    valid_i,
    input  logic [PrioWidth-1:0] prio_i [NumIrq],
    output logic                 valid_o,
    output logic [IdWidth-1:0]   id_o,
    output logic [PrioWidth-1:0] prio_o
);
    logic                 best_valid;
    logic [IdWidth-1:0]   best_id;
    logic [PrioWidth-1:0] best_prio;

    // Strict '>' keeps the earlier (lower) index on equal priority.
    always_comb begin
        best_valid = 1'b0;
        best_id    = '0;
        best_prio  = '0;
        for (int i = 0; i < int'(NumIrq); i++) begin
            if (valid_i[i] && (!best_valid || prio_i[i] > best_prio)) begin
                best_valid = 1'b1;
                best_id    = IdWidth'(i);
                best_prio  = prio_i[i];
            end
        end
    end

    assign valid_o = best_valid;
    assign id_o    = best_id;
    assign prio_o  = best_prio;
endmodule

// File: rtl/hippo_irq_scheduler.sv
// Nested interrupt scheduler: edge-detected pending lines, priority arbitration,
// level stack. Nesting is compiled in with HIPPO_IRQ_NESTING_EN.
module hippo_irq_scheduler
    import hippo_irq_pkg::*;
#(
    parameter int unsigned NumIrq     = DEF_NUM_IRQ,
    parameter int unsigned PrioWidth  = DEF_PRIO_WIDTH,
    parameter int unsigned MaxDepth   = DEF_MAX_DEPTH,
    localparam int unsigned IdWidth    = idx_width(NumIrq),
    localparam int unsigned DepthWidth = $clog2(MaxDepth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumIrq-1:0]     irq_i,
    input  logic                  cfg_we_i,
    input  logic [IdWidth-1:0]    cfg_idx_i,
    input  logic [PrioWidth-1:0]  cfg_prio_i,
    input  logic                  cfg_en_i,
    hippo_irq_scheduler_if.master core_if,
    output logic [PrioWidth-1:0]  level_o,
    output logic [DepthWidth-1:0] depth_o,
    output logic                  err_o
);
`ifdef HIPPO_IRQ_NESTING_EN
    localparam int unsigned DepthLimit = MaxDepth;
`else
    localparam int unsigned DepthLimit = 1;
`endif
    localparam logic [DepthWidth-1:0] DEPTH_LIMIT = DepthWidth'(DepthLimit);

    localparam logic [1:0] IDLE  = FSM_IDLE;
    localparam logic [1:0] REQ   = FSM_REQ;
    localparam logic [1:0] ENTER = FSM_ENTER;
    localparam logic [1:0] EXIT  = FSM_EXIT;

    logic [1:0]            state_q, state_d;
    logic [NumIrq-1:0]     irq_prev_q;
    logic [NumIrq-1:0]     pending_q, pending_d;
    logic [NumIrq-1:0]     en_q;
    logic [PrioWidth-1:0]  prio_q [NumIrq];
    logic [IdWidth-1:0]    lat_id_q, lat_id_d;
    logic [PrioWidth-1:0]  lat_prio_q, lat_prio_d;
    logic [PrioWidth-1:0]  level_q, level_d;
    logic [DepthWidth-1:0] depth_q, depth_d;
    logic                  err_q, err_d;

    logic [NumIrq-1:0]     rising;
    logic [NumIrq-1:0]     eligible;
    logic [NumIrq-1:0]     clear_mask;
    logic                  depth_room;
    logic                  cand_valid;
    logic [IdWidth-1:0]    cand_id;
    logic [PrioWidth-1:0]  cand_prio;
    logic                  cfg_kills_req;
    logic [PrioWidth-1:0]  pop_level;

    assign rising     = irq_i & ~irq_prev_q;
    assign depth_room = (depth_q < DEPTH_LIMIT);

    generate
        for (genvar gi = 0; gi < int'(NumIrq); gi++) begin : g_line
            assign eligible[gi]   = pending_q[gi] && en_q[gi] && (prio_q[gi] != '0)
                                    && (prio_q[gi] > level_q) && depth_room;
            assign clear_mask[gi] = (state_q == ENTER) && (lat_id_q == IdWidth'(gi));
        end
    endgenerate

    hippo_irq_prio_select #(
        .NumIrq    (NumIrq),
        .PrioWidth (PrioWidth)
    ) u_prio_select (
        .valid_i (eligible),
        .prio_i  (prio_q),
        .valid_o (cand_valid),
        .id_o    (cand_id),
        .prio_o  (cand_prio)
    );

    // A config write that makes the latched line no longer beat level_o withdraws the request.
    assign cfg_kills_req = cfg_we_i && (cfg_idx_i == lat_id_q)
                           && (!cfg_en_i || (cfg_prio_i <= level_q));

`ifdef HIPPO_IRQ_NESTING_EN
    logic [PrioWidth-1:0] stack_q [MaxDepth];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(MaxDepth); i++) begin
                stack_q[i] <= '0;
            end
        end else if (state_q == ENTER) begin
            for (int i = 0; i < int'(MaxDepth); i++) begin
                if (depth_q == DepthWidth'(i)) begin
                    stack_q[i] <= level_q;
                end
            end
        end
    end

    always_comb begin
        pop_level = '0;
        for (int i = 0; i < int'(MaxDepth); i++) begin
            if (depth_q == DepthWidth'(i + 1)) begin
                pop_level = stack_q[i];
            end
        end
    end
`else
    assign pop_level = '0;
`endif

    always_comb begin
        state_d    = state_q;
        lat_id_d   = lat_id_q;
        lat_prio_d = lat_prio_q;
        level_d    = level_q;
        depth_d    = depth_q;
        err_d      = err_q;
        case (state_q)
            IDLE, REQ: begin
                if (core_if.mret_i) begin
                    if (depth_q != '0) begin
                        state_d = EXIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (state_q == IDLE) begin
                    if (cand_valid) begin
                        state_d    = REQ;
                        lat_id_d   = cand_id;
                        lat_prio_d = cand_prio;
                    end
                end else if (cfg_kills_req) begin
                    state_d = IDLE;
                end else if (core_if.ack_i) begin
                    state_d = ENTER;
                end
            end
            ENTER: begin
                level_d = lat_prio_q;
                depth_d = depth_q + DepthWidth'(1);
                state_d = IDLE;
            end
            EXIT: begin
                level_d = pop_level;
                depth_d = depth_q - DepthWidth'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh edge on the line being entered survives the clear.
    assign pending_d = (pending_q & ~clear_mask) | rising;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            irq_prev_q <= '0;
            pending_q  <= '0;
            en_q       <= '0;
            lat_id_q   <= '0;
            lat_prio_q <= '0;
            level_q    <= '0;
            depth_q    <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < int'(NumIrq); i++) begin
                prio_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_i;
            pending_q  <= pending_d;
            lat_id_q   <= lat_id_d;
            lat_prio_q <= lat_prio_d;
            level_q    <= level_d;
            depth_q    <= depth_d;
            err_q      <= err_d;
            for (int i = 0; i < int'(NumIrq); i++) begin
                if (cfg_we_i && (cfg_idx_i == IdWidth'(i))) begin
                    en_q[i]   <= cfg_en_i;
                    prio_q[i] <= cfg_prio_i;
                end
            end
        end
    end

    assign core_if.req_o       = (state_q == REQ);
    assign core_if.req_id_o    = lat_id_q;
    assign core_if.req_prio_o  = lat_prio_q;
    assign core_if.stack_cmd_o = (state_q == ENTER) ? STACK_PUSH :
                                 (state_q == EXIT)  ? STACK_POP  : STACK_NONE;

    assign level_o = level_q;
    assign depth_o = depth_q;
    assign err_o   = err_q;
endmodule

// File: tb/tb_hippo_irq_scheduler.sv
// Directed bench for hippo_irq_scheduler; nesting-only steps follow
// HIPPO_IRQ_NESTING_EN.
module tb_hippo_irq_scheduler;
    import hippo_irq_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] irq;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [2:0] cfg_prio;
    logic       cfg_en;
    logic [2:0] level;
    logic [2:0] depth;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;

    hippo_irq_scheduler_if #(.NumIrq(8), .PrioWidth(3)) core_if ();

    hippo_irq_scheduler #(.NumIrq(8), .PrioWidth(3), .MaxDepth(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .irq_i      (irq),
        .cfg_we_i   (cfg_we),
        .cfg_idx_i  (cfg_idx),
        .cfg_prio_i (cfg_prio),
        .cfg_en_i   (cfg_en),
        .core_if    (core_if),
        .level_o    (level),
        .depth_o    (depth),
        .err_o      (err)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [2:0] idx, input logic [2:0] prio, input logic en);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_prio = prio;
        cfg_en   = en;
        tick();
        cfg_we   = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; irq = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_prio = '0; cfg_en = 1'b0;
        core_if.ack_i = 1'b0; core_if.mret_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        chk("rst_req", core_if.req_o, 0);
        chk("rst_cmd", core_if.stack_cmd_o, STACK_NONE);
        chk("rst_level", level, 0);
        chk("rst_depth", depth, 0);
        chk("rst_err", err, 0);
        chk("rst_id", core_if.req_id_o, 0);
        chk("rst_prio", core_if.req_prio_o, 0);

        // Single line 3, priority 2
        cfg(3'd3, 3'd2, 1'b1);
        irq[3] = 1'b1;
        tick();
        chk("a_pend", dut.pending_q[3], 1);
        chk("a_noreq_yet", core_if.req_o, 0);
        tick();
        chk("a_req", core_if.req_o, 1);
        chk("a_id", core_if.req_id_o, 3);
        chk("a_prio", core_if.req_prio_o, 2);
        core_if.ack_i = 1'b1;
        tick();
        core_if.ack_i = 1'b0;
        chk("a_push", core_if.stack_cmd_o, STACK_PUSH);
        tick();
        chk("a_cmd_none", core_if.stack_cmd_o, STACK_NONE);
        chk("a_level", level, 2);
        chk("a_depth", depth, 1);
        chk("a_pend_clr", dut.pending_q[3], 0);
        $display("step A: line 3 entered, level %0d depth %0d", level, depth);

        cfg(3'd6, 3'd5, 1'b1);
        irq[6] = 1'b1;
`ifdef HIPPO_IRQ_NESTING_EN
        tick(); tick();
        chk("n_req", core_if.req_o, 1);
        chk("n_id", core_if.req_id_o, 6);
        chk("n_prio", core_if.req_prio_o, 5);
        core_if.ack_i = 1'b1;
        tick();
        core_if.ack_i = 1'b0;
        chk("n_push", core_if.stack_cmd_o, STACK_PUSH);
        tick();
        chk("n_level5", level, 5);
        chk("n_depth2", depth, 2);
        core_if.mret_i = 1'b1;
        tick();
        core_if.mret_i = 1'b0;
        chk("n_pop1", core_if.stack_cmd_o, STACK_POP);
        tick();
        chk("n_level2", level, 2);
        chk("n_depth1", depth, 1);
        core_if.mret_i = 1'b1;
        tick();
        core_if.mret_i = 1'b0;
        chk("n_pop2", core_if.stack_cmd_o, STACK_POP);
        tick();
        chk("n_level0", level, 0);
        chk("n_depth0", depth, 0);
        $display("step N: nested line 6, unwound to depth %0d", depth);
`else
        tick(); tick(); tick();
        chk("np_noreq", core_if.req_o, 0);
        chk("np_pend6", dut.pending_q[6], 1);
        core_if.ack_i = 1'b1;
        core_if.mret_i = 1'b1;
        tick();
        core_if.ack_i = 1'b0;
        core_if.mret_i = 1'b0;
        chk("np_pop", core_if.stack_cmd_o, STACK_POP);
        tick();
        chk("np_cmd_none", core_if.stack_cmd_o, STACK_NONE);
        chk("np_depth0", depth, 0);
        chk("np_level0", level, 0);
        tick();
        chk("np_req6", core_if.req_o, 1);
        chk("np_id6", core_if.req_id_o, 6);
        chk("np_prio6", core_if.req_prio_o, 5);
        core_if.ack_i = 1'b1;
        tick();
        core_if.ack_i = 1'b0;
        chk("np_push", core_if.stack_cmd_o, STACK_PUSH);
        tick();
        chk("np_level5", level, 5);
        chk("np_depth1", depth, 1);
        core_if.mret_i = 1'b1;
        tick();
        core_if.mret_i = 1'b0;
        chk("np_pop2", core_if.stack_cmd_o, STACK_POP);
        tick();
        chk("np_level_ret", level, 0);
        chk("np_depth_ret", depth, 0);
        $display("step NP: line 6 held off until mret, depth %0d", depth);
`endif

        // mret with nothing to return from
        core_if.mret_i = 1'b1;
        tick();
        core_if.mret_i = 1'b0;
        chk("e_err", err, 1);
        chk("e_cmd", core_if.stack_cmd_o, STACK_NONE);
        chk("e_depth", depth, 0);
        tick();
        chk("e_cmd2", core_if.stack_cmd_o, STACK_NONE);
        chk("e_sticky", err, 1);
        $display("step E: stray mret flagged, err %0d", err);

        // Equal-priority tie between lines 1 and 5
        cfg(3'd1, 3'd4, 1'b1);
        cfg(3'd5, 3'd4, 1'b1);
        irq[1] = 1'b1;
        irq[5] = 1'b1;
        tick(); tick();
        chk("t_req", core_if.req_o, 1);
        chk("t_id1", core_if.req_id_o, 1);
        chk("t_prio", core_if.req_prio_o, 4);
        core_if.ack_i = 1'b1;
        tick();
        core_if.ack_i = 1'b0;
        tick();
        chk("t_level4", level, 4);
        chk("t_pend5", dut.pending_q[5], 1);
        tick(); tick();
        chk("t_no5", core_if.req_o, 0);
        core_if.mret_i = 1'b1;
        tick();
        core_if.mret_i = 1'b0;
        tick(); tick();
        chk("t_req5", core_if.req_o, 1);
        chk("t_id5", core_if.req_id_o, 5);
        cfg(3'd5, 3'd4, 1'b0);
        chk("t_withdrawn", core_if.req_o, 0);
        $display("step T: tie resolved to line 1, line 5 later withdrawn");

        // Disable line 2 while it is being requested
        cfg(3'd2, 3'd3, 1'b1);
        irq[2] = 1'b1;
        tick(); tick();
        chk("d_req", core_if.req_o, 1);
        chk("d_id", core_if.req_id_o, 2);
        cfg(3'd2, 3'd3, 1'b0);
        chk("d_drop", core_if.req_o, 0);
        chk("d_idle", dut.state_q, 0);
        tick();
        chk("d_stay", core_if.req_o, 0);
        $display("step D: line 2 request withdrawn by disable");

        // New edge on line 4 during its own ENTER keeps it pending
        cfg(3'd4, 3'd6, 1'b1);
        irq[4] = 1'b1;
        tick();
        irq[4] = 1'b0;
        tick();
        chk("s_req", core_if.req_o, 1);
        chk("s_id", core_if.req_id_o, 4);
        core_if.ack_i = 1'b1;
        tick();
        core_if.ack_i = 1'b0;
        irq[4] = 1'b1;
        tick();
        chk("s_pend4", dut.pending_q[4], 1);
        chk("s_level6", level, 6);
        chk("s_depth1", depth, 1);
        $display("step S: line 4 re-pended across ENTER");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
